// File: rtl/hazard_controller.sv
// hazard_controller: forwarding, stall/flush and mult/div sequencing for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to add stallCount/flushCount performance counters.
module hazard_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] writeRegE,
    input  logic [4:0] writeRegM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteE,
    input  logic       regWriteM,
    input  logic       regWriteW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       branchD,
    input  logic       branchTakenD,
    input  logic       mdStartE,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       mdBusy,
    output logic       mdDoneE
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             lw_stall, br_stall, md_stall, fwd_m_a, fwd_w_a, fwd_m_b, fwd_w_b;
    always_comb begin
        fwd_m_a   = regWriteM && writeRegM != 5'd0 && writeRegM == RsE;
        fwd_w_a   = regWriteW && writeRegW != 5'd0 && writeRegW == RsE;
        fwd_m_b   = regWriteM && writeRegM != 5'd0 && writeRegM == RtE;
        fwd_w_b   = regWriteW && writeRegW != 5'd0 && writeRegW == RtE;
        forwardAE = fwd_m_a ? 2'b10 : fwd_w_a ? 2'b01 : 2'b00;
        forwardBE = fwd_m_b ? 2'b10 : fwd_w_b ? 2'b01 : 2'b00;
        lw_stall  = memToRegE && RtE != 5'd0 && (RtE == RsD || RtE == RtD);
        br_stall  = branchD && ((regWriteE && writeRegE != 5'd0 && (writeRegE == RsD || writeRegE == RtD)) ||
                                (memToRegM && writeRegM != 5'd0 && (writeRegM == RsD || writeRegM == RtD)));
        md_stall  = (state == IDLE && mdStartE) || state == BUSY;
        stallE    = md_stall;
        stallF    = lw_stall | br_stall | md_stall;
        stallD    = stallF;
        // a bubble into E while E is held would destroy the mult/div in flight
        flushE    = (lw_stall | br_stall) & ~md_stall;
        flushD    = branchTakenD & ~stallD;
        mdBusy    = state != IDLE;
        mdDoneE   = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (state == IDLE && mdStartE) begin
            state <= BUSY;
            cnt   <= CNT_W'(MD_LATENCY - 2);
        end else if (state == BUSY) begin
            if (cnt == '0) state <= DONE;
            else cnt <= cnt - CNT_W'(1);
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            stallCount <= stallCount + {31'd0, stallF};
            flushCount <= flushCount + {31'd0, flushD | flushE};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors with a queue-based scoreboard for hazard_controller.
module tb_hazard_controller;
    logic clk = 1'b0, rst = 1'b1;
    logic [4:0] RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW;
    logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD, branchTakenD, mdStartE;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, flushD, flushE, mdBusy, mdDoneE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCount, flushCount;
`endif
    int checks = 0, failures = 0;
    typedef struct {string n; logic [12:0] v;} exp_t;
    exp_t sb[$];

    hazard_controller #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM), .branchD(branchD),
        .branchTakenD(branchTakenD), .mdStartE(mdStartE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .flushD(flushD), .flushE(flushE), .mdBusy(mdBusy), .mdDoneE(mdDoneE)
`ifdef HAZARD_PERF_EN
       ,.stallCount(stallCount), .flushCount(flushCount)
`endif
    );

    always #5 clk = ~clk;

    // vector layout: {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, mdBusy, mdDoneE}
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [12:0] act;
            e = sb.pop_front();
            act = {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, mdBusy, mdDoneE};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s got=%b expected=%b", e.n, act, e.v);
            end
        end
    end

    task automatic clr();
        {RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW} = '0;
        {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM, branchD, branchTakenD, mdStartE} = '0;
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(string n, logic [12:0] v);
        sb.push_back('{n, v});
    endtask

    initial begin
        clr();
        cyc();
        chk("reset", {2'b00, 2'b00, 7'b0000000});
        rst = 1'b0;
        cyc(); RsE = 5; regWriteM = 1; writeRegM = 5; regWriteW = 1; writeRegW = 5;
        chk("fwdA_M_priority", {2'b10, 2'b00, 7'b0000000});
        cyc(); regWriteM = 0;
        chk("fwdA_W", {2'b01, 2'b00, 7'b0000000});
        cyc(); writeRegW = 0;
        chk("fwdA_W_r0", {2'b00, 2'b00, 7'b0000000});
        cyc(); RtE = 7; regWriteW = 1; writeRegW = 7; regWriteM = 1; writeRegM = 9;
        chk("fwdB_W", {2'b00, 2'b01, 7'b0000000});
        cyc(); clr(); RsE = 0; regWriteM = 1; writeRegM = 0;
        chk("fwdA_M_r0", {2'b00, 2'b00, 7'b0000000});
        cyc(); clr(); memToRegE = 1; RtE = 8; RsD = 8;
        chk("lw_rs", {2'b00, 2'b00, 7'b1100100});
        cyc(); RsD = 0; RtD = 8;
        chk("lw_rt", {2'b00, 2'b00, 7'b1100100});
        cyc(); RtE = 0; RtD = 0;
        chk("lw_r0", {2'b00, 2'b00, 7'b0000000});
        cyc(); clr(); branchD = 1; regWriteE = 1; writeRegE = 3; RtD = 3; branchTakenD = 1;
        chk("br_E_taken", {2'b00, 2'b00, 7'b1100100});
        cyc(); clr(); branchD = 1; memToRegM = 1; writeRegM = 4; RsD = 4;
        chk("br_M_load", {2'b00, 2'b00, 7'b1100100});
        cyc(); clr(); branchD = 1; branchTakenD = 1; regWriteE = 1; writeRegE = 0;
        chk("br_taken_flushD", {2'b00, 2'b00, 7'b0001000});
        cyc(); clr(); regWriteE = 1; writeRegE = 3; RsD = 3;
        chk("no_branch", {2'b00, 2'b00, 7'b0000000});
        // mult/div run with concurrent load-use and taken branch while held
        cyc(); clr(); mdStartE = 1;
        chk("md_c0", {2'b00, 2'b00, 7'b1110000});
        cyc(); clr(); memToRegE = 1; RtE = 8; RsD = 8;
        chk("md_c1_lw", {2'b00, 2'b00, 7'b1110010});
        cyc(); clr(); branchTakenD = 1;
        chk("md_c2_br", {2'b00, 2'b00, 7'b1110010});
        cyc(); clr();
        chk("md_c3", {2'b00, 2'b00, 7'b1110010});
        cyc(); mdStartE = 1;
        chk("md_c4_done", {2'b00, 2'b00, 7'b0000011});
        cyc(); clr();
        chk("md_c5_idle", {2'b00, 2'b00, 7'b0000000});
        // reset in the middle of a mult/div
        cyc(); mdStartE = 1;
        chk("rst_c0", {2'b00, 2'b00, 7'b1110000});
        cyc(); clr();
        chk("rst_c1", {2'b00, 2'b00, 7'b1110010});
        cyc(); rst = 1;
        chk("rst_c2", {2'b00, 2'b00, 7'b1110010});
        cyc(); rst = 0;
        chk("rst_c3", {2'b00, 2'b00, 7'b0000000});
        cyc();
        chk("rst_c4", {2'b00, 2'b00, 7'b0000000});
        cyc();
        chk("rst_c5", {2'b00, 2'b00, 7'b0000000});
        cyc();
`ifdef HAZARD_PERF_EN
        rst = 1;
        cyc(); rst = 0; memToRegE = 1; RtE = 8; RsD = 8;
        cyc(); cyc(); cyc();
        clr(); branchD = 1; branchTakenD = 1;
        cyc(); clr();
        #3;
        checks++;
        if (stallCount !== 32'd3) begin
            failures++;
            $display("FAIL stallCount got=%0d expected=3", stallCount);
        end
        checks++;
        if (flushCount !== 32'd4) begin
            failures++;
            $display("FAIL flushCount got=%0d expected=4", flushCount);
        end
        rst = 1;
        cyc(); rst = 0;
        checks++;
        if (stallCount !== 32'd0 || flushCount !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got=%0d/%0d expected=0/0", stallCount, flushCount);
        end
`endif
        cyc(); cyc();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
